// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream bundle leaving the FIFO read drain.
// Master drives the word and framing; slave returns ready.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a framed valid/ready stream,
// hiding the FIFO's registered read latency in a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  ren,
  fifo_rd_stream_if.master      m,
  output logic                  burst_done,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  rd_err
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  logic [1:0]            rst_sync_q;
  logic                  rst_done;
  occ_e                  occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  word_q, word_d;
  logic                  bd_q, bd_d;
  logic                  err_q, err_d;
  logic                  pop;
  logic                  last;
  logic [1:0]            lvl;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_done = rst_sync_q[1];

  assign m.m_valid  = (occ_q != EMPTY);
  assign m.m_data   = head_q;
  assign last       = (beat_q == LAST_BEAT);
  assign m.m_last   = m.m_valid && last;
  assign pop        = m.m_valid && m.m_ready;
  assign burst_done = bd_q;
  assign word_cnt   = word_q;
  assign rd_err     = err_q;

  // lvl is next-edge occupancy before this cycle's read lands
  assign lvl = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign ren = rst_done && !empty && (lvl <= 2'd1);

  always_comb begin
    occ_d  = occ_e'(lvl);
    infl_d = ren;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    word_d = word_q;
    bd_d   = pop && last;
    err_d  = err_q || (ren && empty);
    if (pop) begin
      head_d = tail_q;
      beat_d = last ? '0 : beat_q + BW'(1);
      word_d = word_q + CNT_WIDTH'(1);
    end
    // arriving word lands in whichever slot is the tail after the pop
    if (infl_q) begin
      if (occ_q == EMPTY || (occ_q == ONE && pop))
        head_d = fifo_dout;
      else
        tail_d = fifo_dout;
    end
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      occ_q  <= EMPTY;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      beat_q <= '0;
      word_q <= '0;
      bd_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      beat_q <= beat_d;
      word_q <= word_d;
      bd_q   <= bd_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: FIFO model feeds the drain, monitor checks order/framing.
// A second small instance covers counter wrap with single-beat bursts.
module tb_fifo_rd_stream;

  localparam int DW = 32;
  localparam int BL = 16;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rst;
  logic          empty;
  logic [DW-1:0] fifo_dout;
  logic          ren;
  logic          burst_done;
  logic [CW-1:0] word_cnt;
  logic          rd_err;

  logic          w_empty;
  logic [7:0]    w_dout;
  logic          w_ren;
  logic          w_bd;
  logic [3:0]    w_cnt;
  logic          w_err;

  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s ();
  fifo_rd_stream_if #(.DATA_WIDTH(8))  ws ();

  fifo_rd_stream #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)
  ) dut (
    .rclk(rclk), .rst(rst), .empty(empty),
    .fifo_dout(fifo_dout), .ren(ren), .m(s.master),
    .burst_done(burst_done), .word_cnt(word_cnt),
    .rd_err(rd_err)
  );

  fifo_rd_stream #(
    .DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)
  ) dut_w (
    .rclk(rclk), .rst(rst), .empty(w_empty),
    .fifo_dout(w_dout), .ren(w_ren), .m(ws.master),
    .burst_done(w_bd), .word_cnt(w_cnt),
    .rd_err(w_err)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int cyc = 0;
  int reads = 0;
  int n_pops = 0;
  int bd_seen = 0;
  int rdy_pct = 100;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  bit ren_prev = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(ren == 1'b0, {tag, "_ren"}, 64'(ren), 0);
    chk(s.m_valid == 1'b0, {tag, "_m_valid"}, 64'(s.m_valid), 0);
    chk(s.m_data == '0, {tag, "_m_data"}, 64'(s.m_data), 0);
    chk(s.m_last == 1'b0, {tag, "_m_last"}, 64'(s.m_last), 0);
    chk(burst_done == 1'b0, {tag, "_burst_done"}, 64'(burst_done), 0);
    chk(word_cnt == '0, {tag, "_word_cnt"}, 64'(word_cnt), 0);
    chk(rd_err == 1'b0, {tag, "_rd_err"}, 64'(rd_err), 0);
  endtask

  // One rclk cycle of the FIFO model and sink: inputs change on the
  // falling edge, ren is sampled 1 unit later, monitor runs at +2.
  task automatic step();
    @(negedge rclk);
    cyc++;
    if (ren_prev) begin
      if (fq.size() > 0) fifo_dout = fq.pop_front();
      else fifo_dout = $urandom;
    end
    empty = (fq.size() == 0);
    s.m_ready = ($urandom_range(99) < rdy_pct);
    #1;
    chk(!(ren && empty), "ren_while_empty", 64'(ren), 0);
    chk((reads - n_pops) <= 2, "occupancy", 64'(reads - n_pops), 2);
    ren_prev = ren;
    if (ren) reads++;
    #2;
  endtask

  task automatic load(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      sb.push_back(w);
    end
  endtask

  logic [DW-1:0] prev_data;
  bit prev_stall = 1'b0;
  bit prev_lastpop = 1'b0;

  always begin
    logic [DW-1:0] e;
    bit exp_last;
    @(negedge rclk);
    #2;
    if (!rst) begin
      n_pops = 0;
      prev_stall = 1'b0;
      prev_lastpop = 1'b0;
    end else begin
      chk(burst_done == prev_lastpop, "burst_done",
          64'(burst_done), 64'(prev_lastpop));
      if (burst_done) bd_seen++;
      chk(word_cnt == CW'(n_pops), "word_cnt",
          64'(word_cnt), 64'(CW'(n_pops)));
      chk(!s.m_last || s.m_valid, "last_without_valid",
          64'(s.m_last), 0);
      if (prev_stall)
        chk(s.m_valid && s.m_data == prev_data, "stall_hold",
            64'(s.m_data), 64'(prev_data));
      prev_lastpop = 1'b0;
      if (s.m_valid && s.m_ready) begin
        chk(sb.size() > 0, "unexpected_word", 64'(s.m_data), 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk(s.m_data == e, "data", 64'(s.m_data), 64'(e));
        end
        exp_last = ((n_pops % BL) == BL - 1);
        chk(s.m_last == exp_last, "m_last",
            64'(s.m_last), 64'(exp_last));
        prev_lastpop = exp_last;
        n_pops++;
        last_pop_cyc = cyc;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      prev_stall = s.m_valid && !s.m_ready;
      prev_data = s.m_data;
    end
  end

  initial begin
    int t;
    int c0;
    int base;
    int bd_base;
    int wp;
    bit wren_prev;
    logic [7:0] wq[$];
    logic [7:0] wsb[$];
    logic [7:0] we;

    rst = 1'b1;
    empty = 1'b1;
    fifo_dout = '0;
    s.m_ready = 1'b0;
    w_empty = 1'b1;
    w_dout = '0;
    ws.m_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) step();
    chk_zero("in_reset");

    // idle after release: nothing may move
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk(ren == 1'b0, "idle_ren", 64'(ren), 0);
      chk(s.m_valid == 1'b0, "idle_valid", 64'(s.m_valid), 0);
    end
    chk_zero("idle");

    // full-rate streaming
    rdy_pct = 100;
    load(256);
    first_pop_cyc = -1;
    c0 = cyc + 1;
    t = 0;
    while (n_pops < 256 && t < 600) begin
      step();
      t++;
    end
    chk(n_pops == 256, "stream_count", 64'(n_pops), 256);
    chk(first_pop_cyc - c0 == 2, "start_latency",
        64'(first_pop_cyc - c0), 2);
    chk(last_pop_cyc - first_pop_cyc == 255, "throughput",
        64'(last_pop_cyc - first_pop_cyc), 255);
    repeat (2) step();
    chk(word_cnt == 16'd256, "stream_word_cnt", 64'(word_cnt), 256);
    chk(bd_seen == 16, "burst_pulses", 64'(bd_seen), 16);

    // random backpressure
    rdy_pct = 30;
    base = n_pops;
    load(256);
    t = 0;
    while (n_pops - base < 256 && t < 4000) begin
      step();
      t++;
    end
    chk(n_pops - base == 256, "bp_count", 64'(n_pops - base), 256);
    chk(sb.size() == 0, "bp_leftover", 64'(sb.size()), 0);
    chk(rd_err == 1'b0, "bp_rd_err", 64'(rd_err), 0);

    // single-cycle empty pulses
    rdy_pct = 100;
    base = n_pops;
    for (int i = 0; i < 8; i++) begin
      load(1);
      repeat (4) step();
    end
    repeat (4) step();
    chk(n_pops - base == 8, "pulse_count", 64'(n_pops - base), 8);

    // counter wrap with single-beat bursts on the narrow instance
    for (int i = 0; i < 20; i++) begin
      we = 8'($urandom);
      wq.push_back(we);
      wsb.push_back(we);
    end
    wp = 0;
    t = 0;
    wren_prev = 1'b0;
    while (wp < 20 && t < 100) begin
      @(negedge rclk);
      if (wren_prev && wq.size() > 0) w_dout = wq.pop_front();
      w_empty = (wq.size() == 0);
      #1;
      chk(!(w_ren && w_empty), "w_ren_while_empty", 64'(w_ren), 0);
      wren_prev = w_ren;
      if (ws.m_valid) begin
        chk(wsb.size() > 0, "w_unexpected", 64'(ws.m_data), 0);
        if (wsb.size() > 0) begin
          we = wsb.pop_front();
          chk(ws.m_data == we, "w_data", 64'(ws.m_data), 64'(we));
        end
        chk(ws.m_last == 1'b1, "w_last", 64'(ws.m_last), 1);
        wp++;
      end
      t++;
    end
    repeat (2) @(negedge rclk);
    #1;
    chk(wp == 20, "w_count", 64'(wp), 20);
    chk(w_cnt == 4'd4, "w_word_cnt", 64'(w_cnt), 4);

    // reset in the middle of a burst with the buffer full
    rdy_pct = 100;
    base = n_pops;
    load(20);
    t = 0;
    while (n_pops - base < 5 && t < 100) begin
      step();
      t++;
    end
    rdy_pct = 0;
    repeat (3) step();
    chk(reads - n_pops == 2, "buffered_before_reset",
        64'(reads - n_pops), 2);
    chk(s.m_valid == 1'b1, "valid_before_reset", 64'(s.m_valid), 1);
    @(negedge rclk);
    rst = 1'b0;
    fq.delete();
    sb.delete();
    ren_prev = 1'b0;
    reads = 0;
    #1;
    chk_zero("mid_reset");
    repeat (2) step();
    rst = 1'b1;
    rdy_pct = 100;
    bd_base = bd_seen;
    load(20);
    t = 0;
    while (n_pops < 20 && t < 200) begin
      step();
      t++;
    end
    chk(n_pops == 20, "post_reset_count", 64'(n_pops), 20);
    repeat (2) step();
    chk(word_cnt == 16'd20, "post_reset_word_cnt", 64'(word_cnt), 20);
    chk(bd_seen - bd_base == 1, "post_reset_bursts",
        64'(bd_seen - bd_base), 1);
    chk(rd_err == 1'b0, "final_rd_err", 64'(rd_err), 0);
    chk(w_err == 1'b0, "final_w_rd_err", 64'(w_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage in the `rclk` domain, directly downstream of the asynchronous FIFO read port. It issues `ren` against the FIFO's `empty` flag, absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer, and presents words as a valid/ready stream framed into fixed-length bursts. It keeps full throughput (one word per `rclk`) while the FIFO is non-empty and the sink is ready, and it never reads an empty FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 32, FIFO word and stream data width.
- `BURST_LEN`, 16, beats per burst; legal range 1..65535.
- `CNT_WIDTH`, 16, width of the running word counter.

Ports:
- `rclk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised to `rclk` internally (2-flop release).
- `empty`  in  1  FIFO empty flag in the `rclk` domain.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid in the cycle after `ren` was sampled high.
- `ren`  out  1  FIFO read enable; combinational.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  DATA_WIDTH  stream word, head of skid buffer.
- `m_last`  out  1  high with the final beat of each burst.
- `m_ready`  in  1  sink accepts when `m_valid && m_ready` (a "pop").
- `burst_done`  out  1  one-cycle registered pulse after the `m_last` beat pops.
- `word_cnt`  out  CNT_WIDTH  total words popped since reset, modulo 2^CNT_WIDTH.
- `rd_err`  out  1  sticky; set if `ren` is ever high while `empty` is high. Cleared only by reset.

## Operation
- Internal state: `occ` (0..2, buffered words), `inflight` (0/1, read issued last cycle), `beat_cnt` (0..BURST_LEN-1).
- Buffer states: EMPTY (occ=0), ONE (occ=1), TWO (occ=2). Transition per edge: occ_next = occ + inflight - pop. Words are stored in arrival order and leave in FIFO order, with no reordering.
- `ren = !empty && (occ + inflight - pop) <= 1`. This term depends combinationally on `m_ready`, which allows back-to-back streaming.
- `inflight_next = ren`. On an edge with `inflight=1`, `fifo_dout` is written into the tail slot.
- A simultaneous arrival and pop in state ONE keeps occ=1. The head is replaced by the arriving word in the same edge.
- A simultaneous arrival and pop in state TWO is impossible by construction, because `ren` was gated the previous cycle.
- `m_valid = (occ != 0)`. `m_data` is the head register and is held stable while `m_valid && !m_ready`.
- `m_last = m_valid && (beat_cnt == BURST_LEN-1)`. On pop, `beat_cnt` increments and wraps to 0 after the last beat. With BURST_LEN=1, `m_last` is high on every beat.
- `word_cnt` increments on every pop and wraps from 2^CNT_WIDTH-1 to 0.
- `rd_err` is a checker only. By construction it never fires in correct operation.
- When reset is asserted mid-stream, buffered and in-flight words are discarded, and `beat_cnt` and `word_cnt` return to 0. Any word read from the FIFO but not yet popped is lost; upstream is reset alongside this stage.

## Timing
- Reset values: `ren`=0 (forced while `rst` is low or the release synchroniser is not yet done), `m_valid`=0, `m_data`=0, `m_last`=0, `burst_done`=0, `word_cnt`=0, `rd_err`=0.
- Latency from `empty` falling to `m_valid` rising, with the buffer empty:
  - Edge E0 samples `ren`=1.
  - Edge E1 captures `fifo_dout`.
  - `m_valid` is high after E1.
- Throughput is 1 word per cycle with `empty`=0 and `m_ready`=1 held.
- When the sink stalls, at most 2 words are buffered. `ren` drops in the same cycle as the stall, and no word is dropped.
- `burst_done` is high for exactly the cycle after the edge that pops the `m_last` beat.

## Test plan
- Reset and idle: hold `rst`=0, then release with `empty`=1. Check `ren`=0 and `m_valid`=0 forever, and all outputs stay 0.
- Streaming: FIFO preloaded with 256 random words, `m_ready`=1. Check:
  - 256 words out in order, one per cycle after the 2-edge start latency.
  - `m_last` on beats 15, 31, …, 255.
  - 16 `burst_done` pulses.
  - `word_cnt`=256.
- Backpressure: toggle `m_ready` randomly at 30% high with a 256-word stream. Check no loss or duplication, `occ` never exceeds 2, `m_data` stable during stalls, and `rd_err`=0.
- Underflow edge: `empty` pulses low for a single cycle, 8 times. Check exactly 8 words out and `ren` never high while `empty`=1.
- Reset mid-burst: assert `rst` after 5 beats with 2 words buffered. Check that outputs clear immediately; after release, the next word pops with `beat_cnt`=0 and `word_cnt` counts from 0.
- Wrap: CNT_WIDTH=4 with BURST_LEN=1 and 20 words. Check `word_cnt` reads 4 at the end and `m_last` is high on every beat.
